// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory sequencing controller.
// Access size codes, FSM states, arbiter grant encoding and the alignment check.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_LD_WR,
      S_DONE
   } state_t;

   typedef enum logic {
      GR_CPU = 1'b0,
      GR_LD  = 1'b1
   } grant_t;

   // True for accesses that must be refused without touching the BRAM.
   function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = lo[0];
         SZ_W:    bad = (lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bus bundle between the CPU MEM stage, the UART loader, the BRAM and dmem_ctrl.
// The slave modport is the controller; master is everything around it.
interface dmem_ctrl_if #(
   parameter int ADDR_W = 14
);
   logic              cpu_req;
   logic              cpu_we;
   logic [1:0]        cpu_size;
   logic              cpu_unsigned;
   logic [31:0]       cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_rdata;
   logic              cpu_done;
   logic              cpu_err;
   logic              cpu_stall;
   logic              ld_req;
   logic [31:0]       ld_addr;
   logic [31:0]       ld_wdata;
   logic              ld_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic              mem_we;
   logic [31:0]       mem_dout;

   modport slave (
      input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_done, cpu_err, cpu_stall,
      input  ld_req, ld_addr, ld_wdata,
      output ld_ack,
      output mem_addr, mem_din, mem_we,
      input  mem_dout
   );

   modport master (
      output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_done, cpu_err, cpu_stall,
      output ld_req, ld_addr, ld_wdata,
      input  ld_ack,
      input  mem_addr, mem_din, mem_we,
      output mem_dout
   );

endinterface

// File: rtl/dmem_lane.sv
// Byte/half lane steering: load extract with sign/zero extension, and the
// store merge used by read-modify-write for sub-word stores.
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] mem_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] merged
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v   = mem_word[{addr_lo, 3'b000} +: 8];
      half_v   = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
      load_val = mem_word;
      merged   = mem_word;
      case (size)
         SZ_B: begin
            load_val = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_H: begin
            load_val = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            if (addr_lo[1]) merged[31:16] = wdata[15:0];
            else            merged[15:0]  = wdata[15:0];
         end
         SZ_W: begin
            merged = wdata;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Sequences CPU loads/stores and UART loader writes onto a single-port,
// synchronous-read BRAM, with one-bit round-robin arbitration between them.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 14
) (
   input logic        clk,
   input logic        rst,
   dmem_ctrl_if.slave bus
);

   localparam int AW2 = ADDR_W + 2;

   state_t        state_q, state_d;
   grant_t        grant_q, grant_d;
   logic [AW2-1:0] addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic [1:0]    size_q, size_d;
   logic          we_q, we_d;
   logic          uns_q, uns_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [31:0]   load_val;
   logic [31:0]   merged;
   logic          pick_ld;
   logic          done;

   dmem_lane u_lane (
      .addr_lo     (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .mem_word    (bus.mem_dout),
      .wdata       (data_q),
      .load_val    (load_val),
      .merged      (merged)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= GR_CPU;
         addr_q  <= '0;
         data_q  <= '0;
         size_q  <= SZ_B;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         size_q  <= size_d;
         we_q    <= we_d;
         uns_q   <= uns_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      data_d  = data_q;
      size_d  = size_q;
      we_d    = we_q;
      uns_d   = uns_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      pick_ld = 1'b0;
      case (state_q)
         S_IDLE: begin
            // On a tie the loader wins only if the CPU had the last grant.
            pick_ld = bus.ld_req & (~bus.cpu_req | (grant_q == GR_CPU));
            if (pick_ld) begin
               grant_d = GR_LD;
               addr_d  = bus.ld_addr[AW2-1:0];
               data_d  = bus.ld_wdata;
               state_d = S_LD_WR;
            end else if (bus.cpu_req) begin
               grant_d = GR_CPU;
               addr_d  = bus.cpu_addr[AW2-1:0];
               data_d  = bus.cpu_wdata;
               size_d  = bus.cpu_size;
               we_d    = bus.cpu_we;
               uns_d   = bus.cpu_unsigned;
               err_d   = 1'b0;
               if (bad_access(bus.cpu_size, bus.cpu_addr[1:0])) begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = S_DONE;
               end else if (bus.cpu_we && (bus.cpu_size == SZ_W)) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: state_d = S_WAIT;
         S_WAIT: begin
            if (we_q) begin
               data_d  = merged;
               state_d = S_WRITE;
            end else begin
               rdata_d = load_val;
               state_d = S_DONE;
            end
         end
         S_WRITE: state_d = S_DONE;
         S_LD_WR: state_d = S_IDLE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // BRAM signals come only from state and registered operands, so reset kills a write at once.
   assign done          = (state_q == S_DONE);
   assign bus.cpu_done  = done;
   assign bus.cpu_err   = done & err_q;
   assign bus.cpu_rdata = rdata_q;
   assign bus.cpu_stall = bus.cpu_req & ~done;
   assign bus.ld_ack    = (state_q == S_LD_WR);
   assign bus.mem_addr  = addr_q[AW2-1:2];
   assign bus.mem_din   = data_q;
   assign bus.mem_we    = (state_q == S_WRITE) | (state_q == S_LD_WR);

endmodule
